// File: rtl/az10_pkg.sv
// Shared AZ10 definitions: default widths, stack pointer sizing and the per-cycle stack op codes.
package az10_pkg;

   localparam int DEF_DATA_LEN = 8;
   localparam int STACK_DEPTH  = 16;

   // Pointer needs one extra bit so that "full" (sp==DEPTH) is representable.
   function automatic int sp_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int SP_W = sp_width(STACK_DEPTH);

   typedef enum logic [2:0] {
      OP_IDLE    = 3'd0,
      OP_PUSH    = 3'd1,
      OP_POP     = 3'd2,
      OP_REPLACE = 3'd3,
      OP_FAULT   = 3'd4
   } op_e;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x DATA_LEN register file: one synchronous write port, one asynchronous read port.
// Zero-latency read; no backpressure, write lands at the next rising edge.
module stack_mem
   import az10_pkg::*;
#(
   parameter int DEPTH    = STACK_DEPTH,
   parameter int DATA_LEN = DEF_DATA_LEN,
   parameter int AW       = $clog2(DEPTH)
)(
   input  logic                clk,
   input  logic                i_we,
   input  logic [AW-1:0]       i_waddr,
   input  logic [DATA_LEN-1:0] i_wdat,
   input  logic [AW-1:0]       i_raddr,
   output logic [DATA_LEN-1:0] o_rdat
);

   // Contents are deliberately not reset; validity is tracked by the stack pointer.
   logic [DATA_LEN-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdat;
      end
   end

   assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/operand_stack.sv
// LIFO operand stack feeding branch targets to the PC; TOS is combinational (zero latency), pops are level-sensitive.
// Optional TOS z/s flags are built when OPERAND_STACK_FLAGS_EN is defined; overflow/underflow are sticky, no backpressure.
module operand_stack
   import az10_pkg::*;
#(
   parameter int DEPTH    = STACK_DEPTH,
   parameter int DATA_LEN = DEF_DATA_LEN
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_LEN-1:0]      data_in,
   input  logic                     err_clr,
   output logic [DATA_LEN-1:0]      data_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     ovf,
   output logic                     unf,
   output logic                     z_flag,
   output logic                     s_flag
);

   localparam int PTR_W = sp_width(DEPTH);
   localparam int AW    = PTR_W - 1;

   logic [PTR_W-1:0]    r_sp;
   logic                r_ovf;
   logic                r_unf;

   logic                w_pop;
   logic                w_empty;
   logic                w_full;
   logic [PTR_W-1:0]    w_sp_m1;
   logic [PTR_W-1:0]    w_sp_nxt;
   logic                w_we;
   logic [AW-1:0]       w_waddr;
   logic [AW-1:0]       w_raddr;
   logic [DATA_LEN-1:0] w_rdat;
   logic                w_set_ovf;
   logic                w_set_unf;
   op_e                 w_op;

   // An unknown or floating pop line must never consume an entry.
   assign w_pop   = (pop === 1'b1);
   assign w_empty = (r_sp == '0);
   assign w_full  = (r_sp == PTR_W'(DEPTH));
   assign w_sp_m1 = r_sp - PTR_W'(1);

   always_comb begin
      w_op = OP_IDLE;
      case ({push, w_pop})
         2'b10:   w_op = w_full  ? OP_FAULT : OP_PUSH;
         2'b01:   w_op = w_empty ? OP_FAULT : OP_POP;
         2'b11:   w_op = w_empty ? OP_PUSH  : OP_REPLACE;
         default: w_op = OP_IDLE;
      endcase
   end

   always_comb begin
      w_sp_nxt = r_sp;
      w_we     = 1'b0;
      w_waddr  = r_sp[AW-1:0];
      case (w_op)
         OP_PUSH: begin
            w_we     = 1'b1;
            w_sp_nxt = r_sp + PTR_W'(1);
         end
         OP_POP: begin
            w_sp_nxt = w_sp_m1;
         end
         OP_REPLACE: begin
            w_we    = 1'b1;
            w_waddr = w_sp_m1[AW-1:0];
         end
         default: begin
            w_sp_nxt = r_sp;
         end
      endcase
      if (!en || rst) begin
         w_we     = 1'b0;
         w_sp_nxt = r_sp;
      end
   end

   // Replace while full is legal, so overflow needs push without pop.
   assign w_set_ovf = en && push && !w_pop && w_full;
   assign w_set_unf = en && w_pop && w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp <= '0;
      end else begin
         r_sp <= w_sp_nxt;
      end
   end

   // A fresh error event outranks err_clr in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_set_ovf) begin
            r_ovf <= 1'b1;
         end else if (err_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_set_unf) begin
            r_unf <= 1'b1;
         end else if (err_clr) begin
            r_unf <= 1'b0;
         end
      end
   end

   assign w_raddr = w_sp_m1[AW-1:0];

   stack_mem #(
      .DEPTH    (DEPTH),
      .DATA_LEN (DATA_LEN),
      .AW       (AW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdat  (data_in),
      .i_raddr (w_raddr),
      .o_rdat  (w_rdat)
   );

   assign data_out = w_empty ? '0 : w_rdat;
   assign count    = r_sp;
   assign empty    = w_empty;
   assign full     = w_full;
   assign ovf      = r_ovf;
   assign unf      = r_unf;

`ifdef OPERAND_STACK_FLAGS_EN
   assign z_flag = !w_empty && (data_out == '0);
   assign s_flag = !w_empty && data_out[DATA_LEN-1];
`else
   assign z_flag = 1'b0;
   assign s_flag = 1'b0;
`endif

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack with hand-computed expectations; flag checks follow OPERAND_STACK_FLAGS_EN.
module tb_operand_stack;

`ifdef OPERAND_STACK_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       err_clr = 1'b0;
   logic [7:0] data_out;
   logic [4:0] count;
   logic       empty, full, ovf, unf, z_flag, s_flag;

   int n_chk = 0;
   int n_err = 0;

   operand_stack #(.DEPTH(16), .DATA_LEN(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .push     (push),
      .pop      (pop),
      .data_in  (data_in),
      .err_clr  (err_clr),
      .data_out (data_out),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .ovf      (ovf),
      .unf      (unf),
      .z_flag   (z_flag),
      .s_flag   (s_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1ns later.
   task automatic cyc(input logic p_push, input logic p_pop, input logic p_en,
                      input logic p_clr, input logic [7:0] p_d);
      push = p_push; pop = p_pop; en = p_en; err_clr = p_clr; data_in = p_d;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0; en = 1'b1; err_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      rst = 1'b0;

      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full",  full,  0);
      chk("rst_ovf",   ovf,   0);
      chk("rst_unf",   unf,   0);
      chk("rst_dout",  data_out, 8'h00);
      chk("rst_z",     z_flag, 0);
      chk("rst_s",     s_flag, 0);

      // Three pushes, then a single-cycle pop.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
      chk("p3_count", count, 3);
      chk("p3_dout",  data_out, 8'h33);
      chk("p3_empty", empty, 0);
      chk("p3_full",  full, 0);

      pop = 1'b1;
      #2;
      chk("pop_pre_dout", data_out, 8'h33);
      @(posedge clk); #1;
      pop = 1'b0;
      chk("pop_post_dout",  data_out, 8'h22);
      chk("pop_post_count", count, 2);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("pop_hold_count", count, 2);

      // Fill, overflow, replace at full, clear while disabled.
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
      chk("fill_count", count, 16);
      chk("fill_full",  full, 1);
      chk("fill_ovf",   ovf, 0);
      chk("fill_dout",  data_out, 8'h0F);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hAA);
      chk("ovf_count", count, 16);
      chk("ovf_full",  full, 1);
      chk("ovf_flag",  ovf, 1);
      chk("ovf_dout",  data_out, 8'h0F);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
      chk("repl_dout",  data_out, 8'h55);
      chk("repl_count", count, 16);
      chk("repl_ovf",   ovf, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("clr_dis_ovf",   ovf, 0);
      chk("clr_dis_count", count, 16);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("full_pop_dout",  data_out, 8'h0E);
      chk("full_pop_count", count, 15);
      chk("full_pop_full",  full, 0);

      // Underflow and clear priority.
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("unf_flag",  unf, 1);
      chk("unf_count", count, 0);
      chk("unf_dout",  data_out, 8'h00);
      chk("unf_empty", empty, 1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
      chk("unf_clr_pri", unf, 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      chk("unf_clr", unf, 0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h66);
      chk("pp_empty_count", count, 1);
      chk("pp_empty_dout",  data_out, 8'h66);
      chk("pp_empty_unf",   unf, 1);
      chk("pp_empty_ovf",   ovf, 0);

      // TOS flags.
      do_reset();
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("z_on_zero", z_flag, FLAGS);
      chk("s_on_zero", s_flag, 0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h80);
      chk("z_on_80", z_flag, 0);
      chk("s_on_80", s_flag, FLAGS);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("flags_empty_cnt", count, 0);
      chk("z_empty", z_flag, 0);
      chk("s_empty", s_flag, 0);

      // Enable gating, then reset beats push.
      do_reset();
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h44);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
      chk("en0_count", count, 1);
      chk("en0_dout",  data_out, 8'h44);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("en0_pop_count", count, 1);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
      rst = 1'b0;
      chk("rstpush_count", count, 0);
      chk("rstpush_empty", empty, 1);
      chk("rstpush_ovf",   ovf, 0);
      chk("rstpush_unf",   unf, 0);
      chk("rstpush_dout",  data_out, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- LIFO operand stack for the AZ10 core. Sits directly upstream of the program counter.
- Supplies branch targets on stk_data_out and honours its one-cycle stk_pop strobe.
- Also accepts pushes from the datapath and exposes top-of-stack (TOS) status flags.
- Single clock domain.

Parameters:
- DEPTH, 16: number of entries (≥2).
- DATA_LEN, 8: entry width in bits; must match the PC's DATA_LEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; when low, no state changes
- push  in  1  push data_in this cycle
- pop  in  1  remove TOS this cycle; only logic 1 counts as asserted
- data_in  in  DATA_LEN  value to push or replace
- err_clr  in  1  clears the sticky error flags
- data_out  out  DATA_LEN  current TOS, combinational
- count  out  $clog2(DEPTH)+1  number of valid entries
- empty  out  1  count==0
- full  out  1  count==DEPTH
- ovf  out  1  sticky: push attempted while full
- unf  out  1  sticky: pop attempted while empty
- z_flag  out  1  TOS==0 (see Optional Feature)
- s_flag  out  1  TOS MSB (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge clk) wins over everything, including en:
  - sp/count=0, empty=1, full=0, ovf=0, unf=0.
  - Memory contents are not cleared.
  - data_out=0, z_flag=0, s_flag=0 while empty.
- data_out = mem[sp-1] combinationally, and 0 when empty.
  - The PC samples data_out at the same edge at which its pop takes effect, so it gets the pre-pop TOS.
  - Zero-latency read is therefore mandatory; no output register.
- Updates (posedge, en=1, rst=0):
  - push only, not full: mem[sp]<=data_in; sp<=sp+1.
  - push only, full: no write, sp unchanged, ovf<=1.
  - pop only, not empty: sp<=sp-1.
  - pop only, empty: sp unchanged, unf<=1.
  - push & pop, not empty: replace, i.e. mem[sp-1]<=data_in, sp unchanged. This is legal when full; ovf is not set.
  - push & pop, empty: acts as push; unf<=1.
  - en=0: no update. Sticky flags hold; err_clr is still honoured.
- err_clr=1 clears ovf/unf. A new error event in the same cycle takes priority and leaves the flag set.
- pop is a level: one entry is removed per cycle it is high. The PC's one-cycle strobe removes exactly one.
- sp never wraps: it saturates at 0 and DEPTH via the guards above.
- full and empty are decoded from sp, combinationally.
- Operation FSM, decoded per cycle from {push,pop,empty,full}: IDLE / PUSH / POP / REPLACE / FAULT. It is a Moore-free decode; only sp, ovf and unf are registered state.

Optional Feature:
- Macro: OPERAND_STACK_FLAGS_EN.
- Defined: z_flag = (!empty && data_out==0); s_flag = (!empty && data_out[DATA_LEN-1]). Both are combinational and feed the PC's conditional branches.
- Undefined: z_flag and s_flag are tied to 0, and the flags come from the ALU instead.

Decomposition:
- Shared package az10_pkg:
  - DATA_LEN default.
  - STACK_DEPTH default.
  - Localparam SP_W = $clog2(DEPTH)+1.
  - Opcode constants for the op decode: OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE, OP_FAULT.
- Sub-module stack_mem: DEPTH×DATA_LEN register file, one synchronous write port, one asynchronous read port. It is the only storage.
- operand_stack holds the pointer logic, error logic and flags.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 -> count=3; data_out=0x33; empty=0, full=0.
- From 3 entries, assert pop for 1 cycle -> data_out=0x33 at the sampling edge; after the edge, data_out=0x22 and count=2.
- Push 16 values (0x00..0x0F), then push 0xAA -> full=1, count=16, ovf=1, data_out=0x0F. Then push+pop with 0x55 -> data_out=0x55, count=16, ovf remains 1 until err_clr.
- Reset, then pop -> unf=1, count=0, data_out=0. Then err_clr together with another pop -> unf stays 1. err_clr alone -> unf=0.
- With OPERAND_STACK_FLAGS_EN: push 0x00 -> z_flag=1, s_flag=0. Push 0x80 -> z_flag=0, s_flag=1. Empty stack -> both 0.
- Push 0x44, then en=0 with push=1 and pop=1 -> no change. Then rst=1 together with push -> count=0, empty=1, ovf=unf=0.
